// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX->MEM elastic stage with a 2-entry skid buffer (main + skid regs).
// Define EXMEM_PERF_EN to build the saturating stall/transfer counters; otherwise they read 0.
module ex_mem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid_e,
  output logic              ready_e,
  input  logic [DATA_W-1:0] alu_result_e,
  input  logic [DATA_W-1:0] store_data_e,
  input  logic [DATA_W-1:0] pc4_e,
  input  logic [4:0]        rd_e,
  input  logic [CTRL_W-1:0] ctrl_e,
  output logic              valid_m,
  input  logic              ready_m,
  output logic [DATA_W-1:0] alu_result_m,
  output logic [DATA_W-1:0] store_data_m,
  output logic [DATA_W-1:0] pc4_m,
  output logic [4:0]        rd_m,
  output logic [CTRL_W-1:0] ctrl_m,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);
  localparam int PW = 3*DATA_W + 5 + CTRL_W;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] in_pkt, main_q, skid_q;
  logic in_fire, out_fire, load_main, load_skid;
  assign in_pkt = {alu_result_e, store_data_e, pc4_e, rd_e, ctrl_e};
  assign {alu_result_m, store_data_m, pc4_m, rd_m, ctrl_m} = main_q;
  assign valid_m = state != EMPTY;
  assign ready_e = state != FULL;
  assign in_fire = valid_e & ready_e;
  assign out_fire = valid_m & ready_m;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EMPTY;
    else state <= state_nxt;
  always_comb begin
    state_nxt = flush ? EMPTY :
                (state == EMPTY) ? (in_fire ? ONE : EMPTY) :
                (state == ONE) ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE) :
                (out_fire ? ONE : FULL);
  end
  // FULL refills main from skid; otherwise main takes the incoming entry
  always_comb begin
    load_main = !flush && ((state == EMPTY && in_fire) || (state == ONE && in_fire && out_fire) ||
                           (state == FULL && out_fire));
    load_skid = !flush && state == ONE && in_fire && !out_fire;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= (state == FULL) ? skid_q : in_pkt;
      if (load_skid) skid_q <= in_pkt;
    end
`ifdef EXMEM_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cnt <= '0;
      xfer_cnt <= '0;
    end else begin
      if (valid_e && !ready_e && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (out_fire && !(&xfer_cnt)) xfer_cnt <= xfer_cnt + 1'b1;
    end
`else
  assign stall_cnt = '0;
  assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: directed + random checks of ex_mem_skid_stage against a 2-deep FIFO model.
module tb_ex_mem_skid_stage;
  localparam int DATA_W = 32, CTRL_W = 16, CNT_W = 4;
  localparam int PW = 3*DATA_W + 5 + CTRL_W;
  logic clk = 0, reset = 1, flush = 0, valid_e = 0, ready_m = 0;
  logic ready_e, valid_m;
  logic [DATA_W-1:0] alu_result_e = 0, store_data_e = 0, pc4_e = 0;
  logic [DATA_W-1:0] alu_result_m, store_data_m, pc4_m;
  logic [4:0] rd_e = 0, rd_m;
  logic [CTRL_W-1:0] ctrl_e = 0, ctrl_m;
  logic [CNT_W-1:0] stall_cnt, xfer_cnt;
  int checks = 0, errors = 0;
  logic [PW-1:0] mq[$];
  int exp_stall = 0, exp_xfer = 0;
  ex_mem_skid_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_e(valid_e), .ready_e(ready_e),
    .alu_result_e(alu_result_e), .store_data_e(store_data_e), .pc4_e(pc4_e), .rd_e(rd_e),
    .ctrl_e(ctrl_e), .valid_m(valid_m), .ready_m(ready_m), .alu_result_m(alu_result_m),
    .store_data_m(store_data_m), .pc4_m(pc4_m), .rd_m(rd_m), .ctrl_m(ctrl_m),
    .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic check_model();
    int lim = (1 << CNT_W) - 1;
    chk("ready_e", ready_e, mq.size() < 2);
    chk("valid_m", valid_m, mq.size() > 0);
    if (mq.size() > 0) chk("head", {alu_result_m, store_data_m, pc4_m, rd_m, ctrl_m}, mq[0]);
`ifdef EXMEM_PERF_EN
    chk("stall_cnt", stall_cnt, exp_stall > lim ? lim : exp_stall);
    chk("xfer_cnt", xfer_cnt, exp_xfer > lim ? lim : exp_xfer);
`else
    chk("stall_cnt", stall_cnt, 0);
    chk("xfer_cnt", xfer_cnt, 0);
`endif
  endtask
  task automatic check_reset_state();
    chk("rst_valid_m", valid_m, 0);
    chk("rst_ready_e", ready_e, 1);
    chk("rst_fields", {alu_result_m, store_data_m, pc4_m, rd_m, ctrl_m}, 0);
    chk("rst_cnts", {stall_cnt, xfer_cnt}, 0);
  endtask
  task automatic step();
    bit rdy = mq.size() < 2;
    bit inf = valid_e && rdy;
    bit outf = mq.size() > 0 && ready_m;
    logic [PW-1:0] pkt = {alu_result_e, store_data_e, pc4_e, rd_e, ctrl_e};
    if (valid_e && !rdy && !flush) exp_stall++;
    if (outf) exp_xfer++;
    @(posedge clk); #1;
    if (flush) mq.delete();
    else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(pkt);
    end
    check_model();
  endtask
  task automatic offer(input logic [DATA_W-1:0] a, input logic [4:0] r);
    valid_e = 1; alu_result_e = a; rd_e = r;
    store_data_e = $urandom; pc4_e = $urandom; ctrl_e = CTRL_W'($urandom);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check_reset_state();
    reset = 0;
    ready_m = 1;
    offer(32'h1000, 5);
    step();
    chk("first_alu", alu_result_m, 32'h1000);
    chk("first_rd", rd_m, 5);
    valid_e = 0;
    step();
    for (int i = 1; i <= 8; i++) begin
      offer(i, 5'(i));
      step();
      chk("stream_order", alu_result_m, i);
    end
    valid_e = 0;
    step();
    chk("stream_drained", valid_m, 0);
    ready_m = 0;
    offer(32'hA, 1); step();
    offer(32'hB, 2); step();
    offer(32'hC, 3); step();
    chk("abc_ready_e", ready_e, 0);
    chk("abc_head_a", alu_result_m, 32'hA);
    step();
    chk("abc_stable_a", alu_result_m, 32'hA);
    ready_m = 1;
    for (int i = 0; i < 6; i++) begin
      bit took = mq.size() < 2;
      step();
      if (took) valid_e = 0;
    end
    chk("abc_drained", valid_m, 0);
    ready_m = 0;
    offer(32'hA, 1); step();
    offer(32'hB, 2); step();
    offer(32'hC, 3); flush = 1; step();
    flush = 0; valid_e = 0;
    chk("flush_valid_m", valid_m, 0);
    chk("flush_ready_e", ready_e, 1);
    ready_m = 1;
    repeat (3) begin
      step();
      chk("flush_no_c", valid_m, 0);
    end
    ready_m = 0;
    offer(32'h11, 4); step();
    offer(32'h22, 6); step();
    #3 reset = 1;
    #1 check_reset_state();
    mq.delete(); exp_stall = 0; exp_xfer = 0;
    #2 reset = 0;
    offer(32'h33, 7);
    repeat (20) step();
`ifdef EXMEM_PERF_EN
    chk("stall_sat", stall_cnt, 15);
`else
    chk("stall_off", stall_cnt, 0);
`endif
    chk("xfer_zero", xfer_cnt, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) offer($urandom, 5'($urandom));
      else valid_e = 0;
      ready_m = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
